mavg_ring: RTL and testbench

Parametrised stereo moving-average filter: next generation of the 8-tap audio averager in the codec datapath. Runs on one system clock with a sample strobe instead of the codec bit clock. Uses a per-channel circular buffer and a running sum, so cost stays flat as depth grows. Adds configurable depth and width, flush, bypass, a priming flag and a registered output strobe. Sits between the ADC deserialiser and the DAC serialiser.

---
 rtl/mavg_pkg.sv | 24 ++
 rtl/mavg_ring_chan.sv | 61 ++++++
 rtl/mavg_ring.sv | 92 +++++++++
 tb/tb_mavg_ring.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mavg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mavg_pkg                                                     |
// | Description : Legal parameter ranges and sizing helpers for mavg_ring.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mavg_pkg;

    localparam int c_sample_w_min   = 8;
    localparam int c_sample_w_max   = 24;
    localparam int c_log2_depth_min = 1;
    localparam int c_log2_depth_max = 6;

    // A sum of 2^log2_depth samples needs log2_depth extra bits to stay exact.
    function automatic int sum_width(input int sample_w, input int log2_depth);
        return sample_w + log2_depth;
    endfunction

    function automatic int round_offset(input int log2_depth);
        return 1 << (log2_depth - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mavg_ring_chan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mavg_ring_chan                                               |
// | Description : One channel: circular history, running sum, round and shift. |
// |               MAVG_ROUND_EN selects round-half-up instead of floor.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mavg_ring_chan
    import mavg_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int LOG2_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_wr_en,
    input  logic [LOG2_DEPTH-1:0] i_wr_ptr,
    input  logic [SAMPLE_W-1:0]   i_sample,
    output logic [SAMPLE_W-1:0]   o_avg
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = sum_width(SAMPLE_W, LOG2_DEPTH);

    logic signed [SAMPLE_W-1:0] r_buf [DEPTH];
    logic signed [SUM_W-1:0]    r_sum;
    logic signed [SUM_W-1:0]    w_x_ext;
    logic signed [SUM_W-1:0]    w_old_ext;
    logic signed [SUM_W-1:0]    w_sum_n;
    logic signed [SUM_W-1:0]    w_rounded;

    assign w_x_ext   = SUM_W'($signed(i_sample));
    assign w_old_ext = SUM_W'(r_buf[i_wr_ptr]);
    // The true window sum always fits SUM_W, so modular wrap of the
    // intermediate terms cancels out.
    assign w_sum_n   = r_sum + w_x_ext - w_old_ext;

`ifdef MAVG_ROUND_EN
    localparam logic signed [SUM_W-1:0] c_round_off = SUM_W'(round_offset(LOG2_DEPTH));
    assign w_rounded = w_sum_n + c_round_off;
`else
    assign w_rounded = w_sum_n;
`endif

    assign o_avg = SAMPLE_W'(w_rounded >>> LOG2_DEPTH);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_sum <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_buf[i_wr_ptr] <= $signed(i_sample);
            r_sum           <= w_sum_n;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mavg_ring.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mavg_ring                                                    |
// | Description : Stereo moving-average filter with flush, bypass and priming. |
// |               Define MAVG_ROUND_EN for round-half-up averaging.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mavg_ring
    import mavg_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int LOG2_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [2*SAMPLE_W-1:0] audioIn,
    input  logic                  flush,
    input  logic                  bypass,
    output logic [2*SAMPLE_W-1:0] audioOut,
    output logic                  out_valid,
    output logic                  primed
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] c_depth    = (LOG2_DEPTH+1)'(DEPTH);
    localparam logic [LOG2_DEPTH:0] c_depth_m1 = (LOG2_DEPTH+1)'(DEPTH - 1);

    if (SAMPLE_W < c_sample_w_min || SAMPLE_W > c_sample_w_max ||
        LOG2_DEPTH < c_log2_depth_min || LOG2_DEPTH > c_log2_depth_max) begin : g_param_err
        $error("mavg_ring: SAMPLE_W or LOG2_DEPTH out of range");
    end

    logic [LOG2_DEPTH-1:0] r_wr_ptr;
    logic [LOG2_DEPTH:0]   r_fill;
    logic                  r_primed;
    logic                  r_out_valid;
    logic [2*SAMPLE_W-1:0] r_audio_out;
    logic [2*SAMPLE_W-1:0] w_avg;
    logic                  w_accept;

    // A sample arriving with flush is dropped.
    assign w_accept = in_valid && !flush;

    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        mavg_ring_chan #(
            .SAMPLE_W   (SAMPLE_W),
            .LOG2_DEPTH (LOG2_DEPTH)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .i_clear  (flush),
            .i_wr_en  (w_accept),
            .i_wr_ptr (r_wr_ptr),
            .i_sample (audioIn[gi*SAMPLE_W +: SAMPLE_W]),
            .o_avg    (w_avg[gi*SAMPLE_W +: SAMPLE_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_primed    <= 1'b0;
            r_out_valid <= 1'b0;
            r_audio_out <= '0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_primed    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_wr_ptr    <= r_wr_ptr + 1'b1;
                r_audio_out <= bypass ? audioIn : w_avg;
                if (r_fill != c_depth) begin
                    r_fill <= r_fill + 1'b1;
                end
                if (r_fill == c_depth_m1) begin
                    r_primed <= 1'b1;
                end
            end
        end
    end

    assign audioOut  = r_audio_out;
    assign out_valid = r_out_valid;
    assign primed    = r_primed;

endmodule
`default_nettype wire

// File: tb/tb_mavg_ring.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mavg_ring                                                 |
// | Description : Self-checking bench for mavg_ring against a window model.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mavg_ring;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] audioIn;
    logic        flush;
    logic        bypass;
    logic [31:0] audioOut;
    logic        out_valid;
    logic        primed;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: last accepted samples per channel, newest at back.
    int          m_hist_l[$];
    int          m_hist_r[$];
    logic [31:0] m_out;
    logic        m_ov;
    logic        m_primed;

    mavg_ring #(.SAMPLE_W(16), .LOG2_DEPTH(3)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .audioIn   (audioIn),
        .flush     (flush),
        .bypass    (bypass),
        .audioOut  (audioOut),
        .out_valid (out_valid),
        .primed    (primed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Mean of an 8-slot window where missing slots count as zero.
    function automatic logic [15:0] window_avg(input int h[$]);
        int s;
        int a;
        s = 0;
        foreach (h[i]) s += h[i];
`ifdef MAVG_ROUND_EN
        s += 4;
`endif
        a = s >>> 3;
        return a[15:0];
    endfunction

    function automatic void model_reset();
        m_hist_l.delete();
        m_hist_r.delete();
        m_out    = '0;
        m_ov     = 1'b0;
        m_primed = 1'b0;
    endfunction

    function automatic void model_step(input logic v, input logic f, input logic b, input logic [31:0] d);
        if (f) begin
            m_hist_l.delete();
            m_hist_r.delete();
            m_ov     = 1'b0;
            m_primed = 1'b0;
        end else if (v) begin
            m_hist_l.push_back(int'($signed(d[31:16])));
            m_hist_r.push_back(int'($signed(d[15:0])));
            if (m_hist_l.size() > 8) begin
                void'(m_hist_l.pop_front());
                void'(m_hist_r.pop_front());
            end
            m_out    = b ? d : {window_avg(m_hist_l), window_avg(m_hist_r)};
            m_ov     = 1'b1;
            m_primed = (m_hist_l.size() == 8);
        end else begin
            m_ov = 1'b0;
        end
    endfunction

    task automatic cycle(input logic v, input logic f, input logic b, input logic [31:0] d);
        in_valid = v;
        flush    = f;
        bypass   = b;
        audioIn  = d;
        @(posedge clk);
        #1;
        model_step(v, f, b, d);
        check("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
        check("primed",    {31'b0, primed},    {31'b0, m_primed});
        check("audioOut",  audioOut, m_out);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        bypass   = 1'b0;
        audioIn  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("rst_out",    audioOut, 32'h0);
        check("rst_valid",  {31'b0, out_valid}, 32'h0);
        check("rst_primed", {31'b0, primed}, 32'h0);
    endtask

    initial begin
        logic [31:0] held;
        logic [15:0] exp16;

        do_reset();

        // Ramp-up from empty history.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0100_0200);
            if (i == 0) check("ramp_first", audioOut, 32'h0020_0040);
            if (i == 6) check("ramp_not_primed", {31'b0, primed}, 32'h0);
        end
        check("ramp_final", audioOut, 32'h0100_0200);
        check("ramp_primed", {31'b0, primed}, 32'h1);

        // Wrap past the buffer end with a linear ramp.
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1, 1'b0, 1'b0, {16'(i), 16'h0});
            if (i % 3 == 0) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        end
`ifdef MAVG_ROUND_EN
        exp16 = 16'd17;
`else
        exp16 = 16'd16;
`endif
        check("wrap_20", {16'h0, audioOut[31:16]}, {16'h0, exp16});

        // Single -1 into a primed zero window.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
`ifdef MAVG_ROUND_EN
        check("neg_round", audioOut, 32'h0000_0000);
`else
        check("neg_floor", audioOut, 32'hFFFF_FFFF);
`endif

        // Full-scale swing in both directions.
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 32'h7FFF_7FFF);
        check("full_pos", audioOut, 32'h7FFF_7FFF);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 32'h8000_8000);
        check("full_neg", audioOut, 32'h8000_8000);

        // Flush colliding with a valid sample.
        held = audioOut;
        cycle(1'b1, 1'b1, 1'b0, 32'h1234_5678);
        check("flush_valid", {31'b0, out_valid}, 32'h0);
        check("flush_primed", {31'b0, primed}, 32'h0);
        check("flush_hold", audioOut, held);
        cycle(1'b1, 1'b0, 1'b0, 32'h0800_0000);
        check("flush_next", audioOut, 32'h0100_0000);

        // Bypass still loads history.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 32'h0400_0400);
            check("bypass_out", audioOut, 32'h0400_0400);
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0400_0400);
        check("bypass_drop", audioOut, 32'h0400_0400);

        // Randomized traffic with occasional flush, bypass and reset.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] d;
            logic        v;
            logic        f;
            logic        b;
            case ($urandom_range(0, 7))
                0:       d = 32'h7FFF_8000;
                1:       d = 32'h8000_7FFF;
                default: d = $urandom;
            endcase
            v = ($urandom_range(0, 9) < 7);
            f = ($urandom_range(0, 49) == 0);
            b = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 999) == 0) do_reset();
            cycle(v, f, b, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
